// File: rtl/x_delay_line_ctrl.sv
// rtl/x_delay_line_ctrl.sv - measurement sequencer for the x_delay_line tapped delay line
// Optional feature macro: X_DL_CTRL_BUBBLE_EN (adds o_bubble thermometer-bubble flag)
`timescale 1ns/1ps
module x_delay_line_ctrl #(
    parameter int DL_WIDTH     = 32,
    parameter int SYNC_LAT     = 2,
    parameter int GAP          = 4,
    parameter int LOG2_SAMPLES = 3,
    localparam int CW          = $clog2(DL_WIDTH + 1),
    localparam int SW          = CW + LOG2_SAMPLES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_go,
    output logic                o_busy,
    output logic                o_dl_start,
    input  logic [DL_WIDTH-1:0] i_dl_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SW-1:0]       o_sum,
    output logic [CW-1:0]       o_avg
`ifdef X_DL_CTRL_BUBBLE_EN
    ,
    output logic                o_bubble
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FIRE  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // One timer serves both the resync wait and the drain gap, so size it for the longer.
    localparam int TMAX = (SYNC_LAT > GAP) ? SYNC_LAT : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int NW   = LOG2_SAMPLES + 1;
    localparam logic [NW-1:0] N_SAMPLES = NW'(2 ** LOG2_SAMPLES);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] code;
    logic          launch;

    // Propagation depth: position of the highest set tap plus one, zero when no tap is set.
    always_comb begin
        code = '0;
        for (int i = 0; i < DL_WIDTH; i++) begin
            if (i_dl_data[i]) begin
                code = CW'(i + 1);
            end
        end
    end

    // Sequencer next-state: fire, wait out resync, capture, drain, repeat, then present result.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    state_d = S_FIRE;
                    launch  = 1'b1;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
                tmr_d   = '0;
            end
            S_WAIT: begin
                if (tmr_q == TW'(SYNC_LAT - 1)) begin
                    state_d = S_CAPT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CAPT: begin
                acc_d   = acc_q + SW'(code);
                cnt_d   = cnt_q + NW'(1);
                tmr_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (tmr_q == TW'(GAP - 1)) begin
                    if (cnt_q == N_SAMPLES) begin
                        state_d = S_DONE;
                        sum_d   = acc_q;
                    end else begin
                        state_d = S_FIRE;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    if (i_go) begin
                        state_d = S_FIRE;
                        launch  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh measurement always starts from an empty accumulator.
        if (launch) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_dl_start = (state_q == S_FIRE);
    assign o_valid    = (state_q == S_DONE);
    assign o_sum      = sum_q;
    assign o_avg      = sum_q[SW-1:LOG2_SAMPLES];

`ifdef X_DL_CTRL_BUBBLE_EN
    logic [DL_WIDTH-1:0] dl_inc;
    logic                is_bubble;
    logic                bubble_q, bubble_d;

    // A clean thermometer (ones from bit 0 up) has no overlap with itself plus one.
    assign dl_inc    = i_dl_data + DL_WIDTH'(1);
    assign is_bubble = |(i_dl_data & dl_inc);

    // Sticky bubble flag for the current measurement, cleared when a new one launches.
    always_comb begin
        bubble_d = bubble_q;
        if ((state_q == S_CAPT) && is_bubble) begin
            bubble_d = 1'b1;
        end
        if (launch) begin
            bubble_d = 1'b0;
        end
    end

    // Bubble flag register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubble_q <= 1'b0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign o_bubble = bubble_q;
`endif

endmodule
